// File: rtl/reindeer_csr_pkg.sv
// Shared constants for the Reindeer machine-mode CSR file.
// Holds the CSR address map, csr_op encodings, the ID register values, the
// interrupt cause codes and the trap-vector helper.
package reindeer_csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CAUSE_W    = 5;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MVENDORID_VAL = 32'h0000_0000;
  localparam logic [31:0] MARCHID_VAL   = 32'h0000_0023;
  localparam logic [31:0] MIMPID_VAL    = 32'h0000_0002;

  localparam logic [CAUSE_W-1:0] CAUSE_MTI       = 5'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_PLAT_BASE = 5'd16;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Vectored mode only redirects interrupts; exceptions always go to base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [31:0] mcause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if ((mtvec[1:0] == MTVEC_VECTORED) && mcause[31]) begin
      return base + {25'd0, mcause[4:0], 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/reindeer_irq_arbiter.sv
// Interrupt capture and arbitration for the Reindeer CSR file.
// Ports: clk/reset_n (sync, active-low); i_timer timer level; i_ext_irq
// platform lines; i_mip_clr software clear mask for edge lines; i_mie_plat /
// i_mtie enables; i_global_ie mstatus.MIE; o_mtip / o_plat_pend captured mip
// bits; o_irq_req / o_irq_code registered request and winning cause.
module reindeer_irq_arbiter
  import reindeer_csr_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned IRQ_W    = 4,
  parameter logic [15:0] IRQ_EDGE = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_timer,
  input  logic [IRQ_W-1:0]   i_ext_irq,
  input  logic [IRQ_W-1:0]   i_mip_clr,
  input  logic [IRQ_W-1:0]   i_mie_plat,
  input  logic               i_mtie,
  input  logic               i_global_ie,
  output logic               o_mtip,
  output logic [IRQ_W-1:0]   o_plat_pend,
  output logic               o_irq_req,
  output logic [CAUSE_W-1:0] o_irq_code
);

  logic [IRQ_W-1:0]   r_ext_d;
  logic [IRQ_W-1:0]   r_pend;
  logic               r_timer_d;
  logic               r_mtip;
  logic               r_irq_req;
  logic [CAUSE_W-1:0] r_irq_code;

  logic [IRQ_W-1:0]   w_pend_nxt;
  logic               w_mtip_nxt;
  logic               w_plat_any;
  logic               w_req;
  logic [CAUSE_W-1:0] w_code;

  // Capture: edge lines latch a rise and hold until software clears them
  // (a rise in the same cycle beats the clear); level lines just mirror.
  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (IRQ_EDGE[i]) begin
        w_pend_nxt[i] = (i_ext_irq[i] & ~r_ext_d[i]) | (r_pend[i] & ~i_mip_clr[i]);
      end else begin
        w_pend_nxt[i] = i_ext_irq[i];
      end
    end
    w_mtip_nxt = i_timer & (r_mtip | ~r_timer_d);
  end

  // Priority: highest enabled platform line, then the machine timer.
  always_comb begin
    w_plat_any = 1'b0;
    w_code     = '0;
    if (r_mtip & i_mtie) begin
      w_code = CAUSE_MTI;
    end
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (r_pend[i] & i_mie_plat[i]) begin
        w_plat_any = 1'b1;
        w_code     = CAUSE_PLAT_BASE + CAUSE_W'(i);
      end
    end
    w_req = i_global_ie & (w_plat_any | (r_mtip & i_mtie));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ext_d    <= '0;
      r_pend     <= '0;
      r_timer_d  <= 1'b0;
      r_mtip     <= 1'b0;
      r_irq_req  <= 1'b0;
      r_irq_code <= '0;
    end else begin
      r_ext_d    <= i_ext_irq;
      r_pend     <= w_pend_nxt;
      r_timer_d  <= i_timer;
      r_mtip     <= w_mtip_nxt;
      r_irq_req  <= w_req;
      r_irq_code <= w_code;
    end
  end

  assign o_mtip      = r_mtip;
  assign o_plat_pend = r_pend;
  assign o_irq_req   = r_irq_req;
  assign o_irq_code  = r_irq_code;

endmodule

// File: rtl/reindeer_csr_ext.sv
// Parametrised machine-mode CSR file for the Reindeer core.
// Ports: clk/reset_n (sync, active-low); exe_enable retire strobe;
// csr_op/csr_addr/csr_wdata access request; rd_en_out/rd_data_out/illegal_out
// registered access response; timer_triggered and ext_irq interrupt sources;
// activate_exception/is_interrupt/exception_code/exception_PC/exception_addr
// trap entry; mret trap return; trap_target_out/mepc_out vectors;
// irq_req/irq_code registered interrupt request.
module reindeer_csr_ext
  import reindeer_csr_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [15:0] IRQ_EDGE      = 16'h0000,
  parameter int unsigned COUNTER_BITS  = 64,
  parameter bit          SMALL_CSR_SET = 1'b0,
  parameter logic [31:0] HART_ID       = 32'h0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                exe_enable,
  input  logic [1:0]                          csr_op,
  input  logic [11:0]                         csr_addr,
  input  logic [XLEN-1:0]                     csr_wdata,
  output logic                                rd_en_out,
  output logic [XLEN-1:0]                     rd_data_out,
  output logic                                illegal_out,
  input  logic                                timer_triggered,
  input  logic [((NUM_IRQ > 0) ? NUM_IRQ : 1)-1:0] ext_irq,
  input  logic                                activate_exception,
  input  logic                                is_interrupt,
  input  logic [4:0]                          exception_code,
  input  logic [XLEN-1:0]                     exception_PC,
  input  logic [XLEN-1:0]                     exception_addr,
  input  logic                                mret,
  output logic [XLEN-1:0]                     trap_target_out,
  output logic [XLEN-1:0]                     mepc_out,
  output logic                                irq_req,
  output logic [4:0]                          irq_code
);

  localparam int unsigned IRQ_W     = (NUM_IRQ > 0) ? NUM_IRQ : 1;
  localparam int unsigned CNT_W     = 64;
  localparam logic [CNT_W-1:0] CNT_MASK = {CNT_W{1'b1}} >> (CNT_W - COUNTER_BITS);
  localparam logic [XLEN-1:0] PLAT_MASK = XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
  localparam logic [XLEN-1:0] MIE_MASK  = PLAT_MASK | XLEN'(32'h80);

  logic [XLEN-1:0]  r_mtvec, r_mepc, r_mtval, r_mcause, r_mscratch, r_mie;
  logic             r_mstatus_mie, r_mstatus_mpie;
  logic [CNT_W-1:0] r_mcycle, r_minstret;
  logic [XLEN-1:0]  r_mcycle_snap, r_minstret_snap;
  logic             r_rd_en, r_illegal;
  logic [XLEN-1:0]  r_rd_data, r_trap_target;

  logic [XLEN-1:0]  w_mstatus, w_mip, w_old, w_new;
  logic             w_known, w_write, w_access, w_illegal, w_rd, w_wr;
  logic [XLEN-1:0]  w_mtvec_nxt, w_mcause_nxt;
  logic [CNT_W-1:0] w_mcycle_nxt, w_minstret_nxt;
  logic [IRQ_W-1:0] w_mip_clr, w_plat_pend;
  logic             w_mtip;

  assign w_mstatus = XLEN'(32'h1800) | XLEN'({r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000});
  assign w_mip     = ((XLEN'(w_plat_pend) << 16) & PLAT_MASK) | XLEN'({w_mtip, 7'd0});

  // Read decode: old value and whether the address exists in this build.
  always_comb begin
    w_known = 1'b1;
    w_old   = '0;
    case (csr_addr)
      CSR_MSTATUS:   w_old = w_mstatus;
      CSR_MIE:       w_old = r_mie;
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MSCRATCH:  w_old = r_mscratch;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MTVAL:     w_old = r_mtval;
      CSR_MIP:       w_old = w_mip;
      CSR_MCYCLE:    begin w_known = !SMALL_CSR_SET; w_old = r_mcycle[31:0];   end
      CSR_MINSTRET:  begin w_known = !SMALL_CSR_SET; w_old = r_minstret[31:0]; end
      CSR_MCYCLEH:   begin w_known = !SMALL_CSR_SET; w_old = r_mcycle_snap;    end
      CSR_MINSTRETH: begin w_known = !SMALL_CSR_SET; w_old = r_minstret_snap;  end
      CSR_MVENDORID: begin w_known = !SMALL_CSR_SET; w_old = MVENDORID_VAL;    end
      CSR_MARCHID:   begin w_known = !SMALL_CSR_SET; w_old = MARCHID_VAL;      end
      CSR_MIMPID:    begin w_known = !SMALL_CSR_SET; w_old = MIMPID_VAL;       end
      CSR_MHARTID:   begin w_known = !SMALL_CSR_SET; w_old = HART_ID;          end
      default:       w_known = 1'b0;
    endcase
  end

  // Access qualification; RS/RC with a zero operand is a pure read.
  always_comb begin
    case (csr_op)
      OP_RS:   w_new = w_old | csr_wdata;
      OP_RC:   w_new = w_old & ~csr_wdata;
      default: w_new = csr_wdata;
    endcase
    w_write   = (csr_op == OP_RW) || (csr_wdata != '0);
    w_access  = (csr_op != OP_NONE) && !activate_exception && !mret;
    w_illegal = w_access && (!w_known || ((csr_addr[11:10] == 2'b11) && w_write));
    w_rd      = w_access && !w_illegal;
    w_wr      = w_rd && w_write;
    w_mip_clr = (w_wr && (csr_addr == CSR_MIP)) ? ~w_new[16 +: IRQ_W] : '0;
  end

  // Next values for registers that also feed the registered trap target.
  always_comb begin
    w_mtvec_nxt  = r_mtvec;
    w_mcause_nxt = r_mcause;
    if (activate_exception) begin
      w_mcause_nxt = {is_interrupt, 26'd0, exception_code};
    end else if (w_wr && (csr_addr == CSR_MCAUSE)) begin
      w_mcause_nxt = w_new;
    end
    if (w_wr && (csr_addr == CSR_MTVEC)) begin
      w_mtvec_nxt = {w_new[31:2], (w_new[1] ? MTVEC_DIRECT : w_new[1:0])};
    end
  end

  // Counters: a software write to either half replaces that cycle's increment.
  always_comb begin
    w_mcycle_nxt   = (r_mcycle + CNT_W'(1)) & CNT_MASK;
    w_minstret_nxt = exe_enable ? ((r_minstret + CNT_W'(1)) & CNT_MASK) : r_minstret;
    if (w_wr && (csr_addr == CSR_MCYCLE))    w_mcycle_nxt   = {r_mcycle[63:32], w_new} & CNT_MASK;
    if (w_wr && (csr_addr == CSR_MCYCLEH))   w_mcycle_nxt   = {w_new, r_mcycle[31:0]} & CNT_MASK;
    if (w_wr && (csr_addr == CSR_MINSTRET))  w_minstret_nxt = {r_minstret[63:32], w_new} & CNT_MASK;
    if (w_wr && (csr_addr == CSR_MINSTRETH)) w_minstret_nxt = {w_new, r_minstret[31:0]} & CNT_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mtvec         <= '0;
      r_mepc          <= '0;
      r_mtval         <= '0;
      r_mcause        <= '0;
      r_mscratch      <= '0;
      r_mie           <= '0;
      r_mstatus_mie   <= 1'b0;
      r_mstatus_mpie  <= 1'b0;
      r_mcycle        <= '0;
      r_minstret      <= '0;
      r_mcycle_snap   <= '0;
      r_minstret_snap <= '0;
      r_rd_en         <= 1'b0;
      r_rd_data       <= '0;
      r_illegal       <= 1'b0;
      r_trap_target   <= '0;
    end else begin
      r_rd_en       <= w_rd;
      r_illegal     <= w_illegal;
      if (w_rd) r_rd_data <= w_old;
      r_mtvec       <= w_mtvec_nxt;
      r_mcause      <= w_mcause_nxt;
      r_trap_target <= trap_target(w_mtvec_nxt, w_mcause_nxt);
      r_mcycle      <= w_mcycle_nxt;
      r_minstret    <= w_minstret_nxt;
      // Low-half access freezes the high half for the following high read.
      if (w_rd && (csr_addr == CSR_MCYCLE))   r_mcycle_snap   <= r_mcycle[63:32];
      if (w_rd && (csr_addr == CSR_MINSTRET)) r_minstret_snap <= r_minstret[63:32];
      if (activate_exception) begin
        r_mepc         <= exception_PC;
        r_mtval        <= exception_addr;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
          end
          CSR_MIE:      r_mie      <= w_new & MIE_MASK;
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= w_new;
          CSR_MTVAL:    r_mtval    <= w_new;
          default:      ;
        endcase
      end
    end
  end

  reindeer_irq_arbiter #(
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_W    (IRQ_W),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_irq_arbiter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_timer     (timer_triggered),
    .i_ext_irq   (ext_irq),
    .i_mip_clr   (w_mip_clr),
    .i_mie_plat  (r_mie[16 +: IRQ_W]),
    .i_mtie      (r_mie[7]),
    .i_global_ie (r_mstatus_mie),
    .o_mtip      (w_mtip),
    .o_plat_pend (w_plat_pend),
    .o_irq_req   (irq_req),
    .o_irq_code  (irq_code)
  );

  assign rd_en_out       = r_rd_en;
  assign rd_data_out     = r_rd_data;
  assign illegal_out     = r_illegal;
  assign trap_target_out = r_trap_target;
  assign mepc_out        = r_mepc;

endmodule

// File: tb/tb_reindeer_csr_ext.sv
// Directed bench for reindeer_csr_ext (NUM_IRQ=4, line 1 edge, 40-bit counters).
module tb_reindeer_csr_ext;

  logic        clk;
  logic        reset_n;
  logic        exe_enable;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        rd_en_out;
  logic [31:0] rd_data_out;
  logic        illegal_out;
  logic        timer_triggered;
  logic [3:0]  ext_irq;
  logic        activate_exception;
  logic        is_interrupt;
  logic [4:0]  exception_code;
  logic [31:0] exception_PC;
  logic [31:0] exception_addr;
  logic        mret;
  logic [31:0] trap_target_out;
  logic [31:0] mepc_out;
  logic        irq_req;
  logic [4:0]  irq_code;

  int n_tests = 0;
  int n_fail  = 0;

  reindeer_csr_ext #(
    .XLEN          (32),
    .NUM_IRQ       (4),
    .IRQ_EDGE      (16'h0002),
    .COUNTER_BITS  (40),
    .SMALL_CSR_SET (1'b0),
    .HART_ID       (32'h5)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .exe_enable         (exe_enable),
    .csr_op             (csr_op),
    .csr_addr           (csr_addr),
    .csr_wdata          (csr_wdata),
    .rd_en_out          (rd_en_out),
    .rd_data_out        (rd_data_out),
    .illegal_out        (illegal_out),
    .timer_triggered    (timer_triggered),
    .ext_irq            (ext_irq),
    .activate_exception (activate_exception),
    .is_interrupt       (is_interrupt),
    .exception_code     (exception_code),
    .exception_PC       (exception_PC),
    .exception_addr     (exception_addr),
    .mret               (mret),
    .trap_target_out    (trap_target_out),
    .mepc_out           (mepc_out),
    .irq_req            (irq_req),
    .irq_code           (irq_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one access for one clock; outputs are sampled on the next falling edge.
  task automatic step(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    @(negedge clk);
    csr_op    = 2'b00;
    csr_wdata = 32'h0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  localparam logic [1:0] RW = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RC = 2'b11;

  initial begin
    reset_n = 1'b0; exe_enable = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
    timer_triggered = 1'b0; ext_irq = 4'h0; activate_exception = 1'b0; is_interrupt = 1'b0;
    exception_code = 5'd0; exception_PC = 32'h0; exception_addr = 32'h0; mret = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en_out), 32'h0);
    chk("rst_rd_data", rd_data_out, 32'h0);
    chk("rst_illegal", 32'(illegal_out), 32'h0);
    chk("rst_irq_req", 32'(irq_req), 32'h0);
    chk("rst_irq_code", 32'(irq_code), 32'h0);
    chk("rst_trap_target", trap_target_out, 32'h0);
    chk("rst_mepc", mepc_out, 32'h0);
    reset_n = 1'b1;

    // mstatus set/clear
    step(RS, 12'h300, 32'h8);
    chk("ms_rs_en", 32'(rd_en_out), 32'h1);
    chk("ms_rs_old", rd_data_out, 32'h1800);
    chk("ms_rs_ill", 32'(illegal_out), 32'h0);
    step(RS, 12'h300, 32'h0);  chk("ms_after_set", rd_data_out, 32'h1808);
    step(RC, 12'h300, 32'h8);  chk("ms_rc_old", rd_data_out, 32'h1808);
    step(RS, 12'h300, 32'h0);  chk("ms_after_clr", rd_data_out, 32'h1800);
    step(RS, 12'h300, 32'h0);  chk("ms_rs0_nochg", rd_data_out, 32'h1800);

    // mtvec and mie
    step(RW, 12'h305, 32'h1001); chk("mtvec_old", rd_data_out, 32'h0);
    step(RS, 12'h305, 32'h0);    chk("mtvec_rd", rd_data_out, 32'h1001);
    step(RW, 12'h304, 32'hFFFF_FFFF);
    step(RW, 12'h304, 32'h0002_0000); chk("mie_mask", rd_data_out, 32'h000F_0080);
    step(RS, 12'h304, 32'h0);    chk("mie_rd", rd_data_out, 32'h0002_0000);
    step(RS, 12'h300, 32'h8);

    // edge interrupt on line 1
    ext_irq = 4'b0010; idle();
    ext_irq = 4'b0000; idle();
    chk("irq17_req", 32'(irq_req), 32'h1);
    chk("irq17_code", 32'(irq_code), 32'd17);
    step(RS, 12'h344, 32'h0); chk("mip_edge", rd_data_out, 32'h0002_0000);

    // trap entry with a concurrent mscratch write that must be dropped
    activate_exception = 1'b1; is_interrupt = 1'b1; exception_code = 5'd17;
    exception_PC = 32'h400; exception_addr = 32'hABC;
    step(RW, 12'h340, 32'hDEAD);
    activate_exception = 1'b0; is_interrupt = 1'b0;
    chk("trap_vec", trap_target_out, 32'h1044);
    chk("trap_mepc", mepc_out, 32'h400);
    chk("trap_drop_rd_en", 32'(rd_en_out), 32'h0);
    chk("trap_drop_ill", 32'(illegal_out), 32'h0);
    step(RS, 12'h300, 32'h0);  chk("trap_mstatus", rd_data_out, 32'h1880);
    chk("trap_irq_off", 32'(irq_req), 32'h0);
    step(RS, 12'h340, 32'h0);  chk("mscratch_kept", rd_data_out, 32'h0);
    step(RS, 12'h342, 32'h0);  chk("mcause", rd_data_out, 32'h8000_0011);
    step(RS, 12'h343, 32'h0);  chk("mtval", rd_data_out, 32'hABC);

    mret = 1'b1; idle(); mret = 1'b0;
    step(RS, 12'h300, 32'h0);  chk("mret_mstatus", rd_data_out, 32'h1888);
    chk("mret_irq_back", 32'(irq_req), 32'h1);

    // edge line held high stays cleared; level line ignores software
    ext_irq = 4'b0011; idle(); idle();
    step(RC, 12'h344, 32'h0003_0000); chk("mip_both", rd_data_out, 32'h0003_0000);
    step(RS, 12'h344, 32'h0);  chk("mip_after_rc", rd_data_out, 32'h0001_0000);
    chk("irq_after_rc", 32'(irq_req), 32'h0);

    // rise and clear in the same cycle: rise wins
    ext_irq = 4'b0000; idle();
    ext_irq = 4'b0010;
    step(RC, 12'h344, 32'h0002_0000); chk("mip_pre_race", rd_data_out, 32'h0);
    step(RS, 12'h344, 32'h0);  chk("mip_set_wins", rd_data_out, 32'h0002_0000);
    ext_irq = 4'b0000;

    // machine timer
    step(RW, 12'h304, 32'h80); chk("mie_old2", rd_data_out, 32'h0002_0000);
    timer_triggered = 1'b1; idle(); idle();
    chk("mti_req", 32'(irq_req), 32'h1);
    chk("mti_code", 32'(irq_code), 32'd7);
    step(RS, 12'h344, 32'h0);  chk("mip_mtip", rd_data_out, 32'h0002_0080);
    timer_triggered = 1'b0; idle(); idle();
    chk("mti_gone", 32'(irq_req), 32'h0);

    // mtvec mode handling and exception (not interrupt) in vectored mode
    step(RW, 12'h305, 32'h2003); chk("mtvec_old2", rd_data_out, 32'h1001);
    step(RS, 12'h305, 32'h0);    chk("mtvec_mode1x", rd_data_out, 32'h2000);
    step(RW, 12'h305, 32'h2001);
    activate_exception = 1'b1; exception_code = 5'd2; exception_PC = 32'h500; exception_addr = 32'h0;
    idle();
    activate_exception = 1'b0;
    chk("exc_vec_base", trap_target_out, 32'h2000);
    chk("exc_mepc", mepc_out, 32'h500);

    // 40-bit mcycle wrap and high-half snapshot
    step(RW, 12'hB00, 32'hFFFF_FFFF);
    step(RW, 12'hB80, 32'hFF);  chk("mcycleh_old", rd_data_out, 32'h0);
    step(RS, 12'hB00, 32'h0);   chk("mcycle_max", rd_data_out, 32'hFFFF_FFFF);
    step(RS, 12'hB80, 32'h0);   chk("mcycleh_snap", rd_data_out, 32'hFF);
    step(RS, 12'hB00, 32'h0);   chk("mcycle_wrap", rd_data_out, 32'h1);
    step(RS, 12'hB80, 32'h0);   chk("mcycleh_wrap", rd_data_out, 32'h0);

    // minstret
    step(RW, 12'hB02, 32'd5);
    exe_enable = 1'b1; idle(); idle(); idle(); exe_enable = 1'b0;
    step(RS, 12'hB02, 32'h0);   chk("minstret_inc", rd_data_out, 32'd8);
    exe_enable = 1'b1;
    step(RW, 12'hB02, 32'd100);
    exe_enable = 1'b0;
    step(RS, 12'hB02, 32'h0);   chk("minstret_wr_wins", rd_data_out, 32'd100);

    // illegal accesses and ID registers
    step(RW, 12'hF11, 32'h1);
    chk("ro_wr_ill", 32'(illegal_out), 32'h1);
    chk("ro_wr_rd_en", 32'(rd_en_out), 32'h0);
    chk("ro_wr_hold", rd_data_out, 32'd100);
    idle();                     chk("ill_pulse", 32'(illegal_out), 32'h0);
    step(RS, 12'hF12, 32'h0);   chk("marchid", rd_data_out, 32'h23);
    step(RS, 12'hF14, 32'h0);   chk("mhartid", rd_data_out, 32'h5);
    step(RS, 12'h7C0, 32'h0);
    chk("unk_ill", 32'(illegal_out), 32'h1);
    chk("unk_rd_en", 32'(rd_en_out), 32'h0);

    // reset during an mepc write
    step(RW, 12'h341, 32'h1234); chk("mepc_wr", mepc_out, 32'h1234);
    csr_op = RW; csr_addr = 12'h341; csr_wdata = 32'h5678; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; csr_op = 2'b00; csr_wdata = 32'h0;
    chk("rstmid_rd_en0", 32'(rd_en_out), 32'h0);
    chk("rstmid_mepc0", mepc_out, 32'h0);
    idle();
    chk("rstmid_rd_en1", 32'(rd_en_out), 32'h0);
    chk("rstmid_mepc1", mepc_out, 32'h0);
    step(RS, 12'h300, 32'h0);   chk("rstmid_mstatus", rd_data_out, 32'h1800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reindeer_csr_ext.md
# reindeer_csr_ext

Parametrised machine-mode CSR file for the Reindeer core: the next-generation replacement for the fixed 32-bit, timer-only CSR block. It adds atomic CSRRW/CSRRS/CSRRC handling, configurable counter width, up to 16 platform interrupt lines with per-line edge or level capture, prioritised interrupt requests, MRET handling and vectored trap targets. It sits beside the execute stage: the pipeline drives one CSR access or trap event per cycle and consumes the trap/return vectors.

## Interface
- XLEN, 32: data width. Only 32 is supported.
- NUM_IRQ, 4: platform interrupt lines, 0..16, mapped to mip/mie bits 16+i.
- IRQ_EDGE, 0: NUM_IRQ-bit mask. 1 = edge-captured line, 0 = level line.
- COUNTER_BITS, 64: mcycle/minstret width, 32..64.
- SMALL_CSR_SET, 0: 1 removes the ID CSRs and counters. Those addresses then read as illegal.
- HART_ID, 0: value returned by mhartid.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- exe_enable  in  1  instruction retired this cycle. Increments minstret.
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write operand.
- rd_en_out  out  1  read data valid.
- rd_data_out  out  XLEN  old CSR value.
- illegal_out  out  1  one-cycle pulse on an illegal access.
- timer_triggered  in  1  timer level from the timer block.
- ext_irq  in  NUM_IRQ  platform interrupt lines.
- activate_exception  in  1  trap entry.
- is_interrupt  in  1  trap is an interrupt.
- exception_code  in  5  cause code.
- exception_PC  in  XLEN  PC to save in mepc.
- exception_addr  in  XLEN  value to save in mtval.
- mret  in  1  return from trap.
- trap_target_out  out  XLEN  trap vector address.
- mepc_out  out  XLEN  current mepc.
- irq_req  out  1  interrupt pending and enabled.
- irq_code  out  5  cause code of the winning interrupt.

## Operation
- Access with csr_op != 00:
  - The old value of the CSR is registered to rd_data_out, and rd_en_out is pulsed.
  - The new value is: RW → wdata; RS → old | wdata; RC → old & ~wdata.
  - RS or RC with csr_wdata == 0 performs no write.
- Illegal access:
  - Applies to an unknown address, or to a write to a read-only CSR (addr[11:10] == 11).
  - illegal_out pulses, no state changes, rd_en_out stays 0, and rd_data_out holds its previous value.
- mstatus:
  - Only MIE (bit 3) and MPIE (bit 7) are stored.
  - MPP (bits 12:11) reads as 11. All other bits read 0.
- Trap entry (activate_exception):
  - mcause ← {is_interrupt, 26'd0, exception_code}.
  - mepc ← exception_PC, mtval ← exception_addr.
  - MPIE ← MIE, then MIE ← 0.
- mret: MIE ← MPIE, MPIE ← 1.
- Priority within one cycle: activate_exception, then mret, then CSR access. A lower-priority access in the same cycle is dropped: no rd_en_out, no illegal_out.
- mip:
  - MTIP (bit 7) sets on the rising edge of timer_triggered and clears when timer_triggered is low.
  - Edge lines set on a rising edge and clear only on a software RC/RW write of 0. If a set and a clear land in the same cycle, the set wins.
  - Level lines mirror ext_irq. Software writes to level lines are ignored.
- irq_req = MIE & |(mip & mie). irq_code is the highest-index pending+enabled platform line (16+i); otherwise MTIP (7).
- Counters:
  - mcycle increments every cycle; minstret increments on exe_enable.
  - Both wrap modulo 2^COUNTER_BITS. Bits at or above COUNTER_BITS read 0.
  - A CSR write to either half wins over that cycle's increment.
  - Reading the low half snapshots the high half. The following mcycleh/minstreth read returns that snapshot.
- trap_target_out:
  - mtvec[1:0] = 00 (direct): mtvec base.
  - mtvec[1:0] = 01 (vectored) and mcause interrupt: base + 4·code.
  - Otherwise: base.
  - Writes of mode 1x store 00.

## Timing
- Read latency: 1 cycle. rd_en_out, rd_data_out and illegal_out are registered.
- A write is visible to an access in the next cycle. Back-to-back accesses to the same CSR return the updated value.
- irq_req and irq_code are registered: 1 cycle after the mip/mie/MIE change.
- trap_target_out is valid the cycle after activate_exception.
- Reset values:
  - All outputs 0.
  - mtvec, mepc, mtval, mcause, mscratch, mie: 0. mip: 0.
  - MIE and MPIE: 0. Counters and snapshots: 0.
  - Edge detectors reset to 0, so an input already high at release is captured as an edge.
- Reset asserted mid-access discards that access; no pulse follows release.

## Structure
- Package reindeer_csr_pkg holds:
  - CSR address constants and csr_op encodings.
  - Vendor, arch and implementation ID constants.
  - Cause codes: MTI = 7, platform base = 16.
- Sub-module reindeer_irq_arbiter holds the per-line edge/level capture, the mip platform bits and the priority encoder. It outputs irq_req and irq_code.

## Test plan
- RS mstatus with 0x8 from reset → rd_data_out = 0x1800, then a read returns 0x1808. RC with 0x8 → 0x1800. RS with wdata 0 → no change.
- Write mtvec = 0x1001, enable mie bit 17 (IRQ_EDGE bit 1 = 1), pulse ext_irq[1] → irq_req = 1, irq_code = 17. activate_exception with is_interrupt = 1, code 17 → trap_target_out = 0x1044, MIE = 0, MPIE = 1. mret → MIE = 1.
- Edge line held high after RC clear of mip bit 17 → stays 0. Level line 0 high with an RC write → mip bit 16 stays 1.
- COUNTER_BITS = 40, write mcycle = 0xFFFFFFFF, mcycleh = 0xFF → wraps to 0 after one cycle. mcycleh reads 0 after a snapshot.
- Write to mvendorid (0xF11) → illegal_out pulse, rd_en_out = 0. Read of 0x7C0 → illegal_out. activate_exception concurrent with an mscratch write → mscratch unchanged.
- reset_n low for 1 cycle during an mepc RW → mepc = 0, rd_en_out = 0 on the next two cycles.
